// File: rtl/esfa_run_scheduler.sv
// Batch sequencer for repeated ESFA engine runs: drives doRun and tallies pass/fail/timeout counts and cycle totals.
// Optional ESFA_SCHED_MAXLAT_EN adds max_cycles, the largest run length seen in the current batch.
module esfa_run_scheduler #(
  parameter int NUM_RUNS = 16,
  parameter int CNT_W    = 8,
  parameter int CYC_W    = 32,
  parameter int TIMEOUT  = 40000,
  parameter int GAP      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             doRun,
  input  logic             isRunning,
  input  logic             wasSuccessful,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CYC_W-1:0] last_cycles,
  output logic [CYC_W-1:0] total_cycles
`ifdef ESFA_SCHED_MAXLAT_EN
  ,
  output logic [CYC_W-1:0] max_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_RUNS + 1);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] CYC_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_SETTLE, S_GAP, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CYC_W-1:0]   cyc_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               aborted_reg;
  logic [CYC_W-1:0]   last_reg, total_reg;

  logic               clear, cyc_inc, settle, timeout_ev, abort_ev, gap_leave;
  logic               timeout_hit;
  logic [IDX_W-1:0]   idx_inc;
  logic [CYC_W:0]     total_sum;

  assign timeout_hit = (TIMEOUT != 0) && (cyc_reg >= TIMEOUT_C);
  assign idx_inc     = idx_reg + IDX_W'(1);
  assign settle      = (state_reg == S_SETTLE);
  assign total_sum   = {1'b0, total_reg} + {1'b0, cyc_reg};

  // Completion (isRunning low in RUN) is checked before timeout so it wins a tie.
  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    cyc_inc    = 1'b0;
    timeout_ev = 1'b0;
    abort_ev   = 1'b0;
    gap_leave  = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_LAUNCH;
          clear      = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_next = S_GAP;
          abort_ev   = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_GAP;
          timeout_ev = 1'b1;
        end else begin
          cyc_inc = 1'b1;
          if (isRunning) state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_GAP;
          abort_ev   = 1'b1;
        end else if (!isRunning) begin
          state_next = S_SETTLE;
        end else if (timeout_hit) begin
          state_next = S_GAP;
          timeout_ev = 1'b1;
        end else begin
          cyc_inc = 1'b1;
        end
      end
      S_SETTLE: state_next = S_GAP;
      S_GAP: begin
        if (abort) begin
          state_next = S_DONE;
        end else if (gap_reg >= GAP_W'(GAP) && !isRunning) begin
          gap_leave  = 1'b1;
          state_next = (aborted_reg || idx_inc >= IDX_W'(NUM_RUNS)) ? S_DONE : S_LAUNCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      cyc_reg     <= '0;
      gap_reg     <= '0;
      idx_reg     <= '0;
      aborted_reg <= 1'b0;
      last_reg    <= '0;
      total_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_LAUNCH && state_reg != S_LAUNCH)
        cyc_reg <= CYC_W'(1);
      else if (cyc_inc && cyc_reg != CYC_MAX)
        cyc_reg <= cyc_reg + CYC_W'(1);
      if (state_next == S_GAP && state_reg != S_GAP)
        gap_reg <= GAP_W'(1);
      else if (state_reg == S_GAP && gap_reg < GAP_W'(GAP))
        gap_reg <= gap_reg + GAP_W'(1);
      if (clear) begin
        idx_reg     <= '0;
        aborted_reg <= 1'b0;
        last_reg    <= '0;
        total_reg   <= '0;
      end else begin
        if (gap_leave) idx_reg <= idx_inc;
        if (abort_ev)  aborted_reg <= 1'b1;
        if (settle) begin
          last_reg  <= cyc_reg;
          total_reg <= total_sum[CYC_W] ? CYC_MAX : total_sum[CYC_W-1:0];
        end else if (timeout_ev) begin
          last_reg <= TIMEOUT_C;
        end
      end
    end
  end

  // Outcome tallies: [0] pass, [1] fail, [2] timeout; each saturates at all-ones.
  logic [2:0]         tally_inc;
  logic [3*CNT_W-1:0] tally_flat;
  assign tally_inc = {timeout_ev, settle & ~wasSuccessful, settle & wasSuccessful};

  for (genvar gi = 0; gi < 3; gi++) begin : g_tally
    logic [CNT_W-1:0] count_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        count_reg <= '0;
      else if (clear)
        count_reg <= '0;
      else if (tally_inc[gi] && count_reg != {CNT_W{1'b1}})
        count_reg <= count_reg + CNT_W'(1);
    end
    assign tally_flat[gi*CNT_W +: CNT_W] = count_reg;
  end

  assign pass_count    = tally_flat[0*CNT_W +: CNT_W];
  assign fail_count    = tally_flat[1*CNT_W +: CNT_W];
  assign timeout_count = tally_flat[2*CNT_W +: CNT_W];
  assign last_cycles   = last_reg;
  assign total_cycles  = total_reg;
  assign doRun         = (state_reg == S_LAUNCH) || (state_reg == S_RUN);
  assign busy          = (state_reg == S_LAUNCH) || (state_reg == S_RUN) ||
                         (state_reg == S_SETTLE) || (state_reg == S_GAP);
  assign done          = (state_reg == S_DONE);

`ifdef ESFA_SCHED_MAXLAT_EN
  logic [CYC_W-1:0] max_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      max_reg <= '0;
    else if (clear)
      max_reg <= '0;
    else if (settle && cyc_reg > max_reg)
      max_reg <= cyc_reg;
    else if (timeout_ev && TIMEOUT_C > max_reg)
      max_reg <= TIMEOUT_C;
  end
  assign max_cycles = max_reg;
`endif

endmodule

// File: tb/tb_esfa_run_scheduler.sv
// Randomized bench for esfa_run_scheduler: a behavioural engine answers doRun; batch results come from arithmetic on run lengths.
// A second instance with 2-bit counters runs in lock-step to exercise saturation.
module tb_esfa_run_scheduler;
  localparam int NR = 4;
  localparam int CW = 8;
  localparam int YW = 32;
  localparam int TO = 120;
  localparam int GP = 4;
  localparam int SW = 2;
  localparam int SAT_MAX = (1 << SW) - 1;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic isRunning = 1'b0, wasSuccessful = 1'b0;
  logic doRun, busy, done;
  logic [CW-1:0] pass_count, fail_count, timeout_count;
  logic [YW-1:0] last_cycles, total_cycles;
  logic sat_doRun, sat_busy, sat_done;
  logic [SW-1:0] sat_pass, sat_fail, sat_to;
  logic [YW-1:0] sat_last, sat_total;
`ifdef ESFA_SCHED_MAXLAT_EN
  logic [YW-1:0] max_cycles, sat_max;
`endif

  esfa_run_scheduler #(.NUM_RUNS(NR), .CNT_W(CW), .CYC_W(YW), .TIMEOUT(TO), .GAP(GP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .doRun(doRun),
    .isRunning(isRunning), .wasSuccessful(wasSuccessful), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .timeout_count(timeout_count),
    .last_cycles(last_cycles), .total_cycles(total_cycles)
`ifdef ESFA_SCHED_MAXLAT_EN
    , .max_cycles(max_cycles)
`endif
  );

  esfa_run_scheduler #(.NUM_RUNS(NR), .CNT_W(SW), .CYC_W(YW), .TIMEOUT(TO), .GAP(GP)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .doRun(sat_doRun),
    .isRunning(isRunning), .wasSuccessful(wasSuccessful), .busy(sat_busy), .done(sat_done),
    .pass_count(sat_pass), .fail_count(sat_fail), .timeout_count(sat_to),
    .last_cycles(sat_last), .total_cycles(sat_total)
`ifdef ESFA_SCHED_MAXLAT_EN
    , .max_cycles(sat_max)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int run_len [NR];
  bit run_ok  [NR];
  int exp_pass, exp_fail, exp_to, exp_last, exp_total, exp_max;

  // Engine model: answers doRun in the same cycle, stays busy run_len cycles, then reports run_ok.
  int eng_idx = 0, eng_rem = 0;
  bit eng_active = 0, eng_armed = 1, eng_ok_q = 0, eng_stuck = 0;
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      isRunning  = 1'b0;
      eng_active = 0;
      eng_armed  = 1;
    end else begin
      if (!busy) eng_idx = 0;
      if (eng_stuck) begin
        isRunning  = 1'b1;
        eng_active = 0;
      end else if (eng_active) begin
        if (eng_rem == 0) begin
          isRunning     = 1'b0;
          eng_active    = 0;
          wasSuccessful = eng_ok_q;
        end else begin
          eng_rem--;
        end
      end else begin
        isRunning = 1'b0;
        if (doRun && eng_armed) begin
          eng_active    = 1;
          eng_armed     = 0;
          eng_rem       = run_len[eng_idx % NR] - 1;
          eng_ok_q      = run_ok[eng_idx % NR];
          eng_idx++;
          isRunning     = 1'b1;
          wasSuccessful = 1'b0;
        end
      end
      if (!doRun) eng_armed = 1;
    end
  end

  // A run of L busy cycles measures L+1; beyond TIMEOUT it is a timeout recorded as TIMEOUT.
  task automatic compute_expected();
    exp_pass = 0; exp_fail = 0; exp_to = 0; exp_last = 0; exp_total = 0; exp_max = 0;
    for (int i = 0; i < NR; i++) begin
      int m;
      m = run_len[i] + 1;
      if (m > TO) begin
        exp_to++;
        exp_last = TO;
        if (TO > exp_max) exp_max = TO;
      end else begin
        if (run_ok[i]) exp_pass++; else exp_fail++;
        exp_last  = m;
        exp_total = exp_total + m;
        if (m > exp_max) exp_max = m;
      end
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_engine();
    for (int w = 0; w < 2000 && isRunning; w++) tick();
  endtask

  task automatic do_start();
    wait_idle_engine();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 5000 && !done; w++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({doRun, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got doRun/busy/done=%b want 000", {doRun, busy, done});
    end
    n_vec++;
    if ({pass_count, fail_count, timeout_count} !== '0) begin
      n_err++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", pass_count, fail_count, timeout_count);
    end
    n_vec++;
    if ({last_cycles, total_cycles} !== '0) begin
      n_err++; $display("FAIL reset_cycles: got last=%0d total=%0d want 0/0", last_cycles, total_cycles);
    end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_fixed_batch();
    for (int i = 0; i < NR; i++) begin run_len[i] = 100; run_ok[i] = 1; end
    compute_expected();
    do_start();
    wait_done();
    n_vec++;
    if ({done, busy} !== 2'b10) begin
      n_err++; $display("FAIL fixed_done: got done/busy=%b want 10", {done, busy});
    end
    n_vec++;
    if ({pass_count, fail_count, timeout_count} !== {CW'(exp_pass), CW'(exp_fail), CW'(exp_to)}) begin
      n_err++; $display("FAIL fixed_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
        pass_count, fail_count, timeout_count, exp_pass, exp_fail, exp_to);
    end
    n_vec++;
    if ({last_cycles, total_cycles} !== {YW'(exp_last), YW'(exp_total)}) begin
      n_err++; $display("FAIL fixed_cycles: got last=%0d total=%0d want %0d/%0d",
        last_cycles, total_cycles, exp_last, exp_total);
    end
    n_vec++;
    if (sat_pass !== SW'(sat(exp_pass))) begin
      n_err++; $display("FAIL fixed_saturate: got pass=%0d want %0d", sat_pass, sat(exp_pass));
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < NR; i++) begin run_len[i] = $urandom_range(100, 20); run_ok[i] = (i % 2 == 0); end
    compute_expected();
    do_start();
    wait_done();
    n_vec++;
    if ({done, pass_count, fail_count, timeout_count} !== {1'b1, CW'(exp_pass), CW'(exp_fail), CW'(exp_to)}) begin
      n_err++; $display("FAIL alternating_counts: got done=%0d %0d/%0d/%0d want 1 %0d/%0d/%0d",
        done, pass_count, fail_count, timeout_count, exp_pass, exp_fail, exp_to);
    end
    n_vec++;
    if ({last_cycles, total_cycles} !== {YW'(exp_last), YW'(exp_total)}) begin
      n_err++; $display("FAIL alternating_cycles: got last=%0d total=%0d want %0d/%0d",
        last_cycles, total_cycles, exp_last, exp_total);
    end
  endtask

  task automatic test_random_batches();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NR; i++) begin run_len[i] = $urandom_range(150, 1); run_ok[i] = $urandom_range(1, 0); end
      compute_expected();
      do_start();
      wait_done();
      n_vec++;
      if ({done, pass_count, fail_count, timeout_count} !== {1'b1, CW'(exp_pass), CW'(exp_fail), CW'(exp_to)}) begin
        n_err++; $display("FAIL random%0d_counts: got done=%0d %0d/%0d/%0d want 1 %0d/%0d/%0d",
          b, done, pass_count, fail_count, timeout_count, exp_pass, exp_fail, exp_to);
      end
      n_vec++;
      if ({last_cycles, total_cycles} !== {YW'(exp_last), YW'(exp_total)}) begin
        n_err++; $display("FAIL random%0d_cycles: got last=%0d total=%0d want %0d/%0d",
          b, last_cycles, total_cycles, exp_last, exp_total);
      end
      n_vec++;
      if ({sat_done, sat_pass, sat_fail, sat_to, sat_last, sat_total} !==
          {1'b1, SW'(sat(exp_pass)), SW'(sat(exp_fail)), SW'(sat(exp_to)), YW'(exp_last), YW'(exp_total)}) begin
        n_err++; $display("FAIL random%0d_sat: got %0d/%0d/%0d last=%0d total=%0d want %0d/%0d/%0d last=%0d total=%0d",
          b, sat_pass, sat_fail, sat_to, sat_last, sat_total,
          sat(exp_pass), sat(exp_fail), sat(exp_to), exp_last, exp_total);
      end
`ifdef ESFA_SCHED_MAXLAT_EN
      n_vec++;
      if (max_cycles !== YW'(exp_max)) begin
        n_err++; $display("FAIL random%0d_max: got %0d want %0d", b, max_cycles, exp_max);
      end
`endif
    end
  endtask

  task automatic test_timeout_stuck();
    int hi, bad;
    for (int i = 0; i < NR; i++) begin run_len[i] = 10; run_ok[i] = 1; end
    wait_idle_engine();
    eng_stuck = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hi = doRun ? 1 : 0;
    for (int w = 0; w < 1000 && doRun; w++) begin
      tick();
      if (doRun) hi++;
    end
    n_vec++;
    if (hi !== TO) begin
      n_err++; $display("FAIL timeout_doRun_cycles: got %0d want %0d", hi, TO);
    end
    bad = 0;
    repeat (20) begin
      tick();
      if (!busy || doRun) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL timeout_gap_hold: got %0d cycles out of GAP want 0", bad);
    end
    n_vec++;
    if ({timeout_count, pass_count, last_cycles} !== {CW'(1), CW'(0), YW'(TO)}) begin
      n_err++; $display("FAIL timeout_record: got to=%0d pass=%0d last=%0d want 1/0/%0d",
        timeout_count, pass_count, last_cycles, TO);
    end
    eng_stuck = 0;
    wait_done();
    n_vec++;
    if ({done, pass_count, timeout_count, last_cycles, total_cycles} !==
        {1'b1, CW'(NR - 1), CW'(1), YW'(11), YW'(11 * (NR - 1))}) begin
      n_err++; $display("FAIL timeout_batch: got done=%0d pass=%0d to=%0d last=%0d total=%0d want 1/%0d/1/11/%0d",
        done, pass_count, timeout_count, last_cycles, total_cycles, NR - 1, 11 * (NR - 1));
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < NR; i++) begin run_len[i] = 40; run_ok[i] = 1; end
    do_start();
    for (int w = 0; w < 2000 && pass_count != 1; w++) tick();
    for (int w = 0; w < 100 && !doRun; w++) tick();
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({doRun, busy} !== 2'b01) begin
      n_err++; $display("FAIL abort_doRun: got doRun/busy=%b want 01", {doRun, busy});
    end
    wait_done();
    n_vec++;
    if ({done, pass_count, fail_count, timeout_count, last_cycles, total_cycles} !==
        {1'b1, CW'(1), CW'(0), CW'(0), YW'(41), YW'(41)}) begin
      n_err++; $display("FAIL abort_result: got done=%0d %0d/%0d/%0d last=%0d total=%0d want 1 1/0/0 41/41",
        done, pass_count, fail_count, timeout_count, last_cycles, total_cycles);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < NR; i++) begin run_len[i] = 30; run_ok[i] = $urandom_range(1, 0); end
    compute_expected();
    do_start();
    for (int w = 0; w < 2000 && (pass_count + fail_count) != 2; w++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if ({busy, 32'(pass_count + fail_count)} !== {1'b1, 32'd2}) begin
      n_err++; $display("FAIL busy_start_ignored: got busy=%0d completed=%0d want 1/2", busy, pass_count + fail_count);
    end
    wait_done();
    n_vec++;
    if ({done, pass_count, fail_count, total_cycles} !== {1'b1, CW'(exp_pass), CW'(exp_fail), YW'(exp_total)}) begin
      n_err++; $display("FAIL busy_start_batch: got done=%0d %0d/%0d total=%0d want 1 %0d/%0d total=%0d",
        done, pass_count, fail_count, total_cycles, exp_pass, exp_fail, exp_total);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < NR; i++) begin run_len[i] = 25; run_ok[i] = 1; end
    do_start();
    for (int w = 0; w < 2000 && pass_count != 1; w++) tick();
    for (int w = 0; w < 100 && !doRun; w++) tick();
    repeat (5) tick();
    #3;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({doRun, busy, done, pass_count, last_cycles, total_cycles} !== '0) begin
      n_err++; $display("FAIL reset_midrun_async: got doRun=%0d busy=%0d pass=%0d last=%0d total=%0d want all 0",
        doRun, busy, pass_count, last_cycles, total_cycles);
    end
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) begin run_len[i] = $urandom_range(60, 5); run_ok[i] = $urandom_range(1, 0); end
    compute_expected();
    do_start();
    wait_done();
    n_vec++;
    if ({done, pass_count, fail_count, last_cycles, total_cycles} !==
        {1'b1, CW'(exp_pass), CW'(exp_fail), YW'(exp_last), YW'(exp_total)}) begin
      n_err++; $display("FAIL reset_fresh_batch: got done=%0d %0d/%0d last=%0d total=%0d want 1 %0d/%0d last=%0d total=%0d",
        done, pass_count, fail_count, last_cycles, total_cycles, exp_pass, exp_fail, exp_last, exp_total);
    end
  endtask

  task automatic test_start_abort_same();
    for (int i = 0; i < NR; i++) begin run_len[i] = $urandom_range(40, 5); run_ok[i] = $urandom_range(1, 0); end
    compute_expected();
    wait_idle_engine();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_vec++;
    if ({busy, doRun, done} !== 3'b110) begin
      n_err++; $display("FAIL start_abort_launch: got busy/doRun/done=%b want 110", {busy, doRun, done});
    end
    wait_done();
    n_vec++;
    if ({done, pass_count, fail_count, total_cycles} !== {1'b1, CW'(exp_pass), CW'(exp_fail), YW'(exp_total)}) begin
      n_err++; $display("FAIL start_abort_batch: got done=%0d %0d/%0d total=%0d want 1 %0d/%0d total=%0d",
        done, pass_count, fail_count, total_cycles, exp_pass, exp_fail, exp_total);
    end
  endtask

`ifdef ESFA_SCHED_MAXLAT_EN
  task automatic test_maxlat();
    run_len[0] = 30; run_len[1] = 80; run_len[2] = 50; run_len[3] = 10;
    for (int i = 0; i < NR; i++) run_ok[i] = 1;
    do_start();
    wait_done();
    n_vec++;
    if ({done, max_cycles} !== {1'b1, YW'(81)}) begin
      n_err++; $display("FAIL maxlat: got done=%0d max=%0d want 1/81", done, max_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_batch();
    test_alternating();
    test_random_batches();
    test_timeout_stuck();
    test_abort();
    test_start_while_busy();
    test_reset_midrun();
    test_start_abort_same();
`ifdef ESFA_SCHED_MAXLAT_EN
    test_maxlat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
